// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: op encoding, ALU select bundle, per-op select table, FSM states.
// Select semantics: {op1,op2} 00=sum 10=AND 01=XOR 11=OR; neg inverts TMP; ncarry_1 inverts carry out; shift_right rotates ACT.
package alu_seq_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBB = 4'd3,
    OP_ANA = 4'd4,
    OP_XRA = 4'd5,
    OP_ORA = 4'd6,
    OP_CMP = 4'd7,
    OP_INR = 4'd8,
    OP_DCR = 4'd9,
    OP_RAR = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic select_op1;
    logic select_op2;
    logic select_neg;
    logic select_ncarry_1;
    logic select_shift_right;
    logic shift_right_in;
  } alu_ctl_t;

  localparam alu_ctl_t CTL_ADD = 6'b000000;
  localparam alu_ctl_t CTL_SUB = 6'b001100;
  localparam alu_ctl_t CTL_ANA = 6'b100000;
  localparam alu_ctl_t CTL_XRA = 6'b010000;
  localparam alu_ctl_t CTL_ORA = 6'b110000;
  // shift_right_in here means "rotate the carry in"; the decoder gates it with CY.
  localparam alu_ctl_t CTL_RAR = 6'b000011;

  localparam alu_ctl_t ALU_CTL_TABLE [16] = '{
    CTL_ADD, CTL_ADD, CTL_SUB, CTL_SUB, CTL_ANA, CTL_XRA, CTL_ORA, CTL_SUB,
    CTL_ADD, CTL_ADD, CTL_RAR, CTL_ADD, CTL_ADD, CTL_ADD, CTL_ADD, CTL_ADD
  };

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_ACT = 3'd1,
    S_FETCH  = 3'd2,
    S_CONST  = 3'd3,
    S_EXEC   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic state_e ld_act_next(alu_op_e op);
    case (op)
      OP_INR, OP_DCR: return S_CONST;
      OP_RAR:         return S_EXEC;
      default:        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command handshake, operand bus handshake and datapath strobes between decoder, sequencer and ALU block.
// slave = sequencer side, master = decoder/datapath side.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic           op_valid;
  logic [OPW-1:0] op_code;
  logic           op_carry;
  logic           op_ready;
  logic           opnd_req;
  logic           opnd_ack;
  logic           a_to_act;
  logic           write_dbus_to_alu_tmp;
  logic           sel_0_fe;
  logic           fe_0_to_act;
  logic           alu_to_a;
  logic           sel_alu_a;
  logic           alu_a_to_dbus;
  logic           select_op1;
  logic           select_op2;
  logic           select_neg;
  logic           select_ncarry_1;
  logic           select_shift_right;
  logic           shift_right_in;
  logic           alu_carry_in;
  logic           flag_we;
  logic           flag_cy_we;
  logic           busy;
  logic           done;
  logic           err_timeout;

  modport slave (
    input  op_valid, op_code, op_carry, opnd_ack,
    output op_ready, opnd_req, a_to_act, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act,
           alu_to_a, sel_alu_a, alu_a_to_dbus, select_op1, select_op2, select_neg,
           select_ncarry_1, select_shift_right, shift_right_in, alu_carry_in,
           flag_we, flag_cy_we, busy, done, err_timeout
  );

  modport master (
    output op_valid, op_code, op_carry, opnd_ack,
    input  op_ready, opnd_req, a_to_act, write_dbus_to_alu_tmp, sel_0_fe, fe_0_to_act,
           alu_to_a, sel_alu_a, alu_a_to_dbus, select_op1, select_op2, select_neg,
           select_ncarry_1, select_shift_right, shift_right_in, alu_carry_in,
           flag_we, flag_cy_we, busy, done, err_timeout
  );

endinterface

// File: rtl/alu_ctl_decode.sv
// Combinational op -> ALU select lines and carry-in rule.
// Zero latency; no handshake.
module alu_ctl_decode
  import alu_seq_pkg::*;
(
  input  alu_op_e  op_i,
  input  logic     carry_i,
  output alu_ctl_t ctl_o,
  output logic     carry_in_o
);

  always_comb begin
    ctl_o                = ALU_CTL_TABLE[op_i];
    ctl_o.shift_right_in = ALU_CTL_TABLE[op_i].shift_right_in & carry_i;
    case (op_i)
      OP_ADC:                         carry_in_o = carry_i;
      OP_SBB:                         carry_in_o = ~carry_i;
      OP_SUB, OP_CMP, OP_INR, OP_DCR: carry_in_o = 1'b1;
      default:                        carry_in_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences ACT/TMP/A strobes and ALU selects for one command; done 4 cycles after accept (3 for RAR), +1 per operand stall.
// op_ready only in IDLE; FETCH waits on opnd_ack, aborting with err_timeout after ACK_TIMEOUT unacked cycles (0 = never).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  alu_op_e         op_q;
  logic            carry_q;
  logic            timeout_d;
  logic            accept;
  logic            exec_d;

  alu_ctl_t        dec_ctl;
  logic            dec_cin;

  logic            op_ready_q, opnd_req_q, a_to_act_q, sel_0_fe_q, fe_0_to_act_q;
  logic            alu_to_a_q, sel_alu_a_q, alu_a_to_dbus_q;
  alu_ctl_t        ctl_q;
  logic            alu_carry_in_q, flag_we_q, flag_cy_we_q;
  logic            busy_q, done_q, err_timeout_q;

  alu_ctl_decode u_dec (
    .op_i       (op_q),
    .carry_i    (carry_q),
    .ctl_o      (dec_ctl),
    .carry_in_o (dec_cin)
  );

  assign accept = (state_q == S_IDLE) && bus.op_valid && op_ready_q;
  assign exec_d = (state_d == S_EXEC);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LD_ACT;
      S_LD_ACT: begin
        state_d = ld_act_next(op_q);
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (bus.opnd_ack) begin
          state_d = S_EXEC;
        end else if (ACK_TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CONST:  state_d = S_EXEC;
      S_EXEC:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so the datapath sees them a full cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      op_q            <= OP_ADD;
      carry_q         <= 1'b0;
      op_ready_q      <= 1'b0;
      opnd_req_q      <= 1'b0;
      a_to_act_q      <= 1'b0;
      sel_0_fe_q      <= 1'b0;
      fe_0_to_act_q   <= 1'b0;
      alu_to_a_q      <= 1'b0;
      sel_alu_a_q     <= 1'b0;
      alu_a_to_dbus_q <= 1'b0;
      ctl_q           <= '0;
      alu_carry_in_q  <= 1'b0;
      flag_we_q       <= 1'b0;
      flag_cy_we_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= alu_op_e'(bus.op_code);
        carry_q <= bus.op_carry;
      end
      op_ready_q      <= (state_d == S_IDLE);
      busy_q          <= state_d inside {S_LD_ACT, S_FETCH, S_CONST, S_EXEC};
      a_to_act_q      <= (state_d == S_LD_ACT);
      opnd_req_q      <= (state_d == S_FETCH);
      sel_0_fe_q      <= (state_d == S_CONST);
      fe_0_to_act_q   <= (state_d == S_CONST) && (op_q == OP_DCR);
      ctl_q           <= exec_d ? dec_ctl : '0;
      alu_carry_in_q  <= exec_d && dec_cin;
      alu_to_a_q      <= exec_d && (op_q != OP_CMP);
      sel_alu_a_q     <= exec_d;
      flag_we_q       <= exec_d;
      flag_cy_we_q    <= exec_d && !(op_q inside {OP_INR, OP_DCR});
      done_q          <= (state_d == S_DONE);
      alu_a_to_dbus_q <= (state_d == S_DONE);
      err_timeout_q   <= timeout_d;
    end
  end

  // TMP load must follow the ack in the same cycle, so this one strobe is not registered.
  assign bus.write_dbus_to_alu_tmp = rst_n && (state_q == S_FETCH) && bus.opnd_ack;

  assign bus.op_ready           = op_ready_q;
  assign bus.opnd_req           = opnd_req_q;
  assign bus.a_to_act           = a_to_act_q;
  assign bus.sel_0_fe           = sel_0_fe_q;
  assign bus.fe_0_to_act        = fe_0_to_act_q;
  assign bus.alu_to_a           = alu_to_a_q;
  assign bus.sel_alu_a          = sel_alu_a_q;
  assign bus.alu_a_to_dbus      = alu_a_to_dbus_q;
  assign bus.select_op1         = ctl_q.select_op1;
  assign bus.select_op2         = ctl_q.select_op2;
  assign bus.select_neg         = ctl_q.select_neg;
  assign bus.select_ncarry_1    = ctl_q.select_ncarry_1;
  assign bus.select_shift_right = ctl_q.select_shift_right;
  assign bus.shift_right_in     = ctl_q.shift_right_in;
  assign bus.alu_carry_in       = alu_carry_in_q;
  assign bus.flag_we            = flag_we_q;
  assign bus.flag_cy_we         = flag_cy_we_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.err_timeout        = err_timeout_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Drives alu_op_sequencer against a negedge-capturing ACT/TMP/A/flags datapath model with a programmable-delay operand bus.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_e    op;
    logic [7:0] a0;
    logic       cy0;
    logic [7:0] opnd;
    int         dly;
    logic [7:0] exp_a;
    logic       exp_z;
    logic       exp_cy;
    logic [7:0] exp_tmp;
    int         exp_lat;
    logic       exp_wr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [7:0] a_reg, act, tmp, dbus_val;
  logic       z, cy;
  int         n_done, n_req, n_err;
  logic       saw_wr, saw_fw;
  int         n_vec, n_bad;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {bus.op_ready, bus.opnd_req, bus.write_dbus_to_alu_tmp, bus.a_to_act, bus.sel_0_fe,
            bus.fe_0_to_act, bus.alu_to_a, bus.sel_alu_a, bus.alu_a_to_dbus, bus.select_op1,
            bus.select_op2, bus.select_neg, bus.select_ncarry_1, bus.select_shift_right,
            bus.shift_right_in, bus.alu_carry_in, bus.flag_we, bus.flag_cy_we, bus.busy,
            bus.done, bus.err_timeout};
  endfunction

  function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] b;
    logic [8:0] r;
    b = bus.select_neg ? ~y : y;
    if (bus.select_shift_right) r = {x[0], bus.shift_right_in, x[7:1]};
    else begin
      case ({bus.select_op1, bus.select_op2})
        2'b00:   r = {1'b0, x} + {1'b0, b} + {8'b0, bus.alu_carry_in};
        2'b10:   r = {1'b0, x & b};
        2'b01:   r = {1'b0, x ^ b};
        default: r = {1'b0, x | b};
      endcase
    end
    return r;
  endfunction

  // One clock: datapath captures at negedge, then return 1 time unit after the next posedge.
  task automatic tick();
    logic [8:0] r;
    logic       cyn;
    @(negedge clk);
    r   = alu_f(act, tmp);
    cyn = bus.select_ncarry_1 ? ~r[8] : r[8];
    if (bus.write_dbus_to_alu_tmp) tmp = dbus_val;
    if (bus.sel_0_fe) tmp = bus.fe_0_to_act ? 8'hFE : 8'h00;
    if (bus.a_to_act) act = a_reg;
    if (bus.alu_to_a) begin
      a_reg  = r[7:0];
      saw_wr = 1'b1;
    end
    if (bus.flag_we) begin
      saw_fw = 1'b1;
      z      = (r[7:0] == 8'h00);
      if (bus.flag_cy_we) cy = cyn;
    end
    if (bus.done) n_done++;
    if (bus.opnd_req) n_req++;
    if (bus.err_timeout) n_err++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_op_e op);
    int k;
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_carry = cy;
    k = 0;
    while (!bus.op_ready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.op_ready) chk("op_ready before accept", 32'(bus.op_ready), 32'd1);
    tick();
    bus.op_valid = 1'b0;
  endtask

  // Called in the first cycle after the accept edge; lat counts cycles from that edge.
  task automatic finish_cmd(input int dly, input logic ack_en, output int lat, output logic got_done,
                            output logic got_err, output logic rdy_at_err, output logic [2:0] df);
    int waited;
    waited = 0; lat = 0; got_done = 1'b0; got_err = 1'b0; rdy_at_err = 1'b0; df = '0;
    for (int c = 1; c <= 60; c++) begin
      lat = c;
      if (bus.done) begin
        got_done = 1'b1;
        df = {bus.alu_a_to_dbus, bus.sel_alu_a, bus.busy};
        break;
      end
      if (bus.err_timeout) begin
        got_err    = 1'b1;
        rdy_at_err = bus.op_ready;
        break;
      end
      if (bus.opnd_req) begin
        bus.opnd_ack = ack_en && (waited >= dly);
        waited++;
      end else begin
        bus.opnd_ack = 1'b0;
      end
      tick();
    end
    bus.opnd_ack = 1'b0;
    if (got_done || got_err) tick();
    else chk("command end within 60 cycles", 32'd0, 32'd1);
  endtask

  initial begin
    int         lat;
    logic       gd, ge, rdy;
    logic [2:0] df;
    int         exp_req;

    n_vec = 0; n_bad = 0;
    a_reg = 8'h00; act = 8'h00; tmp = 8'h00; dbus_val = 8'h00; z = 1'b0; cy = 1'b0;
    n_done = 0; n_req = 0; n_err = 0; saw_wr = 1'b0; saw_fw = 1'b0;

    //           op      a0     cy0   opnd   dly exp_a  z     cy    tmp    lat wr
    vecs[0]  = '{OP_ADD, 8'h3C, 1'b0, 8'h0F, 0, 8'h4B, 1'b0, 1'b0, 8'h0F, 4, 1'b1};
    vecs[1]  = '{OP_SUB, 8'h05, 1'b0, 8'h05, 3, 8'h00, 1'b1, 1'b0, 8'h05, 7, 1'b1};
    vecs[2]  = '{OP_INR, 8'hFF, 1'b1, 8'h00, 0, 8'h00, 1'b1, 1'b1, 8'h00, 4, 1'b1};
    vecs[3]  = '{OP_DCR, 8'h00, 1'b0, 8'h00, 0, 8'hFF, 1'b0, 1'b0, 8'hFE, 4, 1'b1};
    vecs[4]  = '{OP_CMP, 8'h42, 1'b0, 8'h42, 0, 8'h42, 1'b1, 1'b0, 8'h42, 4, 1'b0};
    vecs[5]  = '{OP_ADC, 8'hF0, 1'b1, 8'h10, 0, 8'h01, 1'b0, 1'b1, 8'h10, 4, 1'b1};
    vecs[6]  = '{OP_SBB, 8'h10, 1'b1, 8'h01, 0, 8'h0E, 1'b0, 1'b0, 8'h01, 4, 1'b1};
    vecs[7]  = '{OP_SBB, 8'h00, 1'b1, 8'h00, 0, 8'hFF, 1'b0, 1'b1, 8'h00, 4, 1'b1};
    vecs[8]  = '{OP_ANA, 8'hF0, 1'b1, 8'h3C, 0, 8'h30, 1'b0, 1'b0, 8'h3C, 4, 1'b1};
    vecs[9]  = '{OP_XRA, 8'h55, 1'b1, 8'h55, 0, 8'h00, 1'b1, 1'b0, 8'h55, 4, 1'b1};
    vecs[10] = '{OP_ORA, 8'hA0, 1'b0, 8'h05, 0, 8'hA5, 1'b0, 1'b0, 8'h05, 4, 1'b1};
    vecs[11] = '{OP_RAR, 8'h01, 1'b0, 8'h77, 0, 8'h00, 1'b1, 1'b1, 8'h00, 3, 1'b1};
    vecs[12] = '{OP_RAR, 8'h80, 1'b1, 8'h77, 0, 8'hC0, 1'b0, 1'b0, 8'h00, 3, 1'b1};
    vecs[13] = '{OP_SUB, 8'h00, 1'b0, 8'h01, 1, 8'hFF, 1'b0, 1'b1, 8'h01, 5, 1'b1};

    rst_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_carry = 1'b0; bus.opnd_ack = 1'b0;
    tick(); tick(); tick();
    chk("outputs in reset", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("op_ready first cycle after reset", 32'(bus.op_ready), 32'd1);
    chk("busy idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < NV; i++) begin
      a_reg = vecs[i].a0; cy = vecs[i].cy0; z = ~vecs[i].exp_z;
      act = 8'h00; tmp = 8'h00; dbus_val = vecs[i].opnd;
      n_req = 0; n_done = 0; saw_wr = 1'b0;
      exp_req = (vecs[i].op inside {OP_INR, OP_DCR, OP_RAR}) ? 0 : vecs[i].dly + 1;
      issue(vecs[i].op);
      finish_cmd(vecs[i].dly, 1'b1, lat, gd, ge, rdy, df);
      chk($sformatf("v%0d done", i),        32'(gd),     32'd1);
      chk($sformatf("v%0d A", i),           32'(a_reg),  32'(vecs[i].exp_a));
      chk($sformatf("v%0d Z", i),           32'(z),      32'(vecs[i].exp_z));
      chk($sformatf("v%0d CY", i),          32'(cy),     32'(vecs[i].exp_cy));
      chk($sformatf("v%0d TMP", i),         32'(tmp),    32'(vecs[i].exp_tmp));
      chk($sformatf("v%0d latency", i),     32'(lat),    32'(vecs[i].exp_lat));
      chk($sformatf("v%0d alu_to_a", i),    32'(saw_wr), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d opnd_req cyc", i), 32'(n_req), 32'(exp_req));
      chk($sformatf("v%0d done strobes", i), 32'(df),    32'b100);
      chk($sformatf("v%0d back to idle", i), 32'(bus.op_ready), 32'd1);
    end

    // Operand never acked: abort after 15 FETCH cycles, A and flags untouched.
    a_reg = 8'h77; cy = 1'b0; z = 1'b0; act = 8'h00; tmp = 8'h00; dbus_val = 8'h11;
    n_req = 0; n_done = 0; n_err = 0; saw_wr = 1'b0; saw_fw = 1'b0;
    issue(OP_ADD);
    finish_cmd(0, 1'b0, lat, gd, ge, rdy, df);
    chk("timeout err_timeout", 32'(ge),     32'd1);
    chk("timeout op_ready",    32'(rdy),    32'd1);
    chk("timeout fetch cyc",   32'(n_req),  32'd15);
    chk("timeout latency",     32'(lat),    32'd17);
    chk("timeout A",           32'(a_reg),  32'h77);
    chk("timeout flag_we",     32'(saw_fw), 32'd0);
    chk("timeout alu_to_a",    32'(saw_wr), 32'd0);
    tick();
    chk("timeout pulse width", 32'(n_err),  32'd1);
    chk("timeout no done",     32'(n_done), 32'd0);

    // Reset asserted during EXEC of an ADD, with an INR held on op_valid across the reset.
    a_reg = 8'h10; cy = 1'b0; act = 8'h00; tmp = 8'h00; dbus_val = 8'h01; n_done = 0;
    issue(OP_ADD);
    for (int k = 0; k < 10 && !bus.flag_we; k++) begin
      bus.opnd_ack = bus.opnd_req;
      tick();
    end
    bus.opnd_ack = 1'b0;
    chk("reached EXEC", 32'(bus.flag_we), 32'd1);
    rst_n = 1'b0;
    bus.op_valid = 1'b1; bus.op_code = OP_INR; bus.op_carry = cy;
    tick();
    chk("abort outputs zero", 32'(outs()), 32'd0);
    tick();
    chk("held in reset busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("op_ready after release", 32'(bus.op_ready), 32'd1);
    tick();
    chk("accepted after release", 32'({bus.busy, bus.a_to_act}), 32'b11);
    bus.op_valid = 1'b0;
    finish_cmd(0, 1'b1, lat, gd, ge, rdy, df);
    chk("post-reset INR done", 32'(gd),     32'd1);
    chk("single done only",    32'(n_done), 32'd1);
    chk("post-reset INR A",    32'(a_reg),  32'h12);
    chk("post-reset latency",  32'(lat),    32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
